// File: rtl/reg8file_core.sv
// reg8file_core
//   8-entry x WIDTH register array fed by the one-hot write enables of the
//   3-to-8 write-select decoder. Two registered read ports (latency 1),
//   per-entry "written since reset" bits, a registered valid count and a
//   sticky error flag for malformed (multi-hot) write enables.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   out_en   in   [7:0]       write enables, bit i selects entry i
//   wdata    in   [WIDTH-1:0] write data
//   rd_en    in   read request
//   raddr_a  in   [2:0]       read address, port A
//   raddr_b  in   [2:0]       read address, port B
//   rdata_a  out  [WIDTH-1:0] registered read data, port A
//   rdata_b  out  [WIDTH-1:0] registered read data, port B
//   a_vld    out  entry at raddr_a written since reset
//   b_vld    out  entry at raddr_b written since reset
//   rvalid   out  one-cycle pulse marking updated read outputs
//   nvalid   out  [3:0]       number of entries written since reset
//   wr_err   out  sticky multi-hot write flag
//   err_clr  in   clears wr_err (a simultaneous set wins)
module reg8file_core #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned BYPASS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       out_en,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_en,
   input  logic [2:0]       raddr_a,
   input  logic [2:0]       raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic             a_vld,
   output logic             b_vld,
   output logic             rvalid,
   output logic [3:0]       nvalid,
   output logic             wr_err,
   input  logic             err_clr
);

   logic [WIDTH-1:0] r_mem [8];
   logic [7:0]       r_valid;
   logic [WIDTH-1:0] r_rdata_a;
   logic [WIDTH-1:0] r_rdata_b;
   logic             r_a_vld;
   logic             r_b_vld;
   logic             r_rvalid;
   logic [3:0]       r_nvalid;
   logic             r_wr_err;

   logic             w_multi;
   logic             w_onehot;
   logic [7:0]       w_valid_nxt;
   logic [3:0]       w_nvalid_nxt;
   logic             w_byp_a;
   logic             w_byp_b;
   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;
   logic             w_vld_a;
   logic             w_vld_b;

   // x & (x-1) clears the lowest set bit; anything left means two or more bits.
   assign w_multi  = (out_en & (out_en - 8'd1)) != 8'd0;
   assign w_onehot = (out_en != 8'd0) && !w_multi;

   assign w_valid_nxt = r_valid | (w_onehot ? out_en : 8'd0);

   always_comb begin
      w_nvalid_nxt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         w_nvalid_nxt = w_nvalid_nxt + {3'd0, w_valid_nxt[i]};
      end
   end

   // Write-first forwarding applies only to a legal (one-hot) write.
   assign w_byp_a = (BYPASS != 0) && w_onehot && out_en[raddr_a];
   assign w_byp_b = (BYPASS != 0) && w_onehot && out_en[raddr_b];

   assign w_rd_a  = w_byp_a ? wdata : r_mem[raddr_a];
   assign w_rd_b  = w_byp_b ? wdata : r_mem[raddr_b];
   assign w_vld_a = w_byp_a | r_valid[raddr_a];
   assign w_vld_b = w_byp_b | r_valid[raddr_b];

   // Storage and valid tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            r_mem[i] <= '0;
         end
         r_valid  <= 8'd0;
         r_nvalid <= 4'd0;
      end else begin
         if (w_onehot) begin
            for (int i = 0; i < 8; i++) begin
               if (out_en[i]) begin
                  r_mem[i] <= wdata;
               end
            end
         end
         r_valid  <= w_valid_nxt;
         r_nvalid <= w_nvalid_nxt;
      end
   end

   // Read ports
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata_a <= '0;
         r_rdata_b <= '0;
         r_a_vld   <= 1'b0;
         r_b_vld   <= 1'b0;
         r_rvalid  <= 1'b0;
      end else begin
         r_rvalid <= rd_en;
         if (rd_en) begin
            r_rdata_a <= w_rd_a;
            r_rdata_b <= w_rd_b;
            r_a_vld   <= w_vld_a;
            r_b_vld   <= w_vld_b;
         end
      end
   end

   // Sticky error: set beats clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_err <= 1'b0;
      end else if (w_multi) begin
         r_wr_err <= 1'b1;
      end else if (err_clr) begin
         r_wr_err <= 1'b0;
      end
   end

   assign rdata_a = r_rdata_a;
   assign rdata_b = r_rdata_b;
   assign a_vld   = r_a_vld;
   assign b_vld   = r_b_vld;
   assign rvalid  = r_rvalid;
   assign nvalid  = r_nvalid;
   assign wr_err  = r_wr_err;

endmodule
